// File: rtl/button_gesture.sv
// Classifies a debounced button level into single-click, double-click and
// long-press event pulses using one FSM and a single shared up-counter.
module button_gesture #(
  parameter int LONG_TICKS   = 50,
  parameter int DOUBLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  localparam int MAX_TICKS = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT2     = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_click;
  logic            r_double_click;
  logic            r_long_press;
  logic            w_long_hit;
  logic            w_double_hit;

  // Terminal-count matches compare the counter value before this edge's increment.
  assign w_long_hit   = (r_cnt == CW'(LONG_TICKS - 1));
  assign w_double_hit = (r_cnt == CW'(DOUBLE_TICKS - 1));

  // Gesture FSM, shared counter and one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_click        <= 1'b0;
      r_double_click <= 1'b0;
      r_long_press   <= 1'b0;
    end else begin
      r_click        <= 1'b0;
      r_double_click <= 1'b0;
      r_long_press   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (btn_level) begin
            r_cnt   <= '0;
            r_state <= S_PRESS1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PRESS1: begin
          r_cnt <= r_cnt + CW'(1);
          // A release on the terminal edge wins over the long-press timeout.
          if (!btn_level) begin
            r_cnt   <= '0;
            r_state <= S_WAIT2;
          end else if (w_long_hit) begin
            r_long_press <= 1'b1;
            r_state      <= S_LONG_HELD;
          end else begin
            r_state <= S_PRESS1;
          end
        end
        S_WAIT2: begin
          r_cnt <= r_cnt + CW'(1);
          if (btn_level) begin
            r_cnt   <= '0;
            r_state <= S_PRESS2;
          end else if (w_double_hit) begin
            r_click <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT2;
          end
        end
        S_PRESS2: begin
          r_cnt <= r_cnt + CW'(1);
          if (!btn_level) begin
            r_double_click <= 1'b1;
            r_state        <= S_IDLE;
          end else if (w_long_hit) begin
            r_double_click <= 1'b1;
            r_state        <= S_LONG_HELD;
          end else begin
            r_state <= S_PRESS2;
          end
        end
        S_LONG_HELD: begin
          if (btn_level) begin
            r_state <= S_LONG_HELD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign click        = r_click;
  assign double_click = r_double_click;
  assign long_press   = r_long_press;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_button_gesture.sv
// Directed gesture bench for button_gesture (LONG_TICKS=8, DOUBLE_TICKS=4):
// stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_button_gesture;

  logic clk;
  logic rst;
  logic btn_level;
  logic click;
  logic double_click;
  logic long_press;
  logic busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0] ev;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [2:0] EV_CLICK  = 3'b001;
  localparam logic [2:0] EV_DOUBLE = 3'b010;
  localparam logic [2:0] EV_LONG   = 3'b100;

  button_gesture #(.LONG_TICKS(8), .DOUBLE_TICKS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every event pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (click || double_click || long_press) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got ev=%b at cycle %0d, required none", {long_press, double_click, click}, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({long_press, double_click, click} !== e.ev || cyc != e.at) begin
          bad++;
          $display("FAIL event: got ev=%b at cycle %0d, required ev=%b at cycle %0d",
                   {long_press, double_click, click}, cyc, e.ev, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_level = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [2:0] ev, input int at);
    exp_t e;
    e.ev = ev;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  int base;

  initial begin
    rst       = 1'b1;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_click",  int'(click), 0);
    chk("reset_double", int'(double_click), 0);
    chk("reset_long",   int'(long_press), 0);
    chk("reset_busy",   int'(busy), 0);
    rst = 1'b0;
    hold(1'b0, 2);

    // Single click: high 3, low -> click 4 edges after the release edge.
    base = cyc + 1;
    expect_ev(EV_CLICK, base + 7);
    hold(1'b1, 3);
    hold(1'b0, 6);
    drain_check("single_click");
    chk("single_busy_idle", int'(busy), 0);

    // Double click: high 2, low 2, high 3, low.
    base = cyc + 1;
    expect_ev(EV_DOUBLE, base + 7);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 6);
    drain_check("double_click");

    // Long press: high 12 edges, no event at release.
    base = cyc + 1;
    expect_ev(EV_LONG, base + 8);
    hold(1'b1, 1);
    chk("long_busy_pressed", int'(busy), 1);
    hold(1'b1, 11);
    hold(1'b0, 2);
    chk("long_busy_released", int'(busy), 0);
    drain_check("long_press");

    // Release on the terminal long-press edge -> click instead.
    base = cyc + 1;
    expect_ev(EV_CLICK, base + 12);
    hold(1'b1, 8);
    hold(1'b0, 6);
    drain_check("release_priority");

    // Second press on the terminal click edge -> double click instead.
    base = cyc + 1;
    expect_ev(EV_DOUBLE, base + 7);
    hold(1'b1, 2);
    hold(1'b0, 4);
    hold(1'b1, 1);
    hold(1'b0, 6);
    drain_check("press2_priority");

    // Reset while waiting for a second press (counter = 2): no click.
    hold(1'b1, 2);
    hold(1'b0, 3);
    chk("wait2_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    rst = 1'b0;
    hold(1'b0, 8);
    drain_check("mid_reset");

    // Long second press: single double_click, then held until release.
    base = cyc + 1;
    expect_ev(EV_DOUBLE, base + 11);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 10);
    chk("long2_busy_held", int'(busy), 1);
    hold(1'b0, 3);
    chk("long2_busy_released", int'(busy), 0);
    drain_check("long_second_press");

    // Button already high when reset releases starts a gesture.
    rst       = 1'b1;
    btn_level = 1'b1;
    repeat (2) @(negedge clk);
    chk("hot_reset_busy", int'(busy), 0);
    rst  = 1'b0;
    base = cyc + 1;
    expect_ev(EV_CLICK, base + 7);
    hold(1'b1, 3);
    hold(1'b0, 6);
    drain_check("high_at_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_gesture.md
BUTTON_GESTURE -- requirements
Module: button_gesture

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 50: number of clock edges a press must be held to count as a long press (minimum 2).
REQ-002 SHALL have parameter DOUBLE_TICKS, default 20: number of clock edges after a release during which a second press makes a double click (minimum 2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port btn_level  input  1  debounced button level from a debouncer (1 = pressed), synchronous to clk.
REQ-006 SHALL have port click  output  1  single-click event pulse.
REQ-007 SHALL have port double_click  output  1  double-click event pulse.
REQ-008 SHALL have port long_press  output  1  long-press event pulse.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in S_IDLE.

Function
REQ-010 SHALL implement the FSM states S_IDLE, S_PRESS1, S_WAIT2, S_PRESS2 and S_LONG_HELD, with one shared up-counter.
REQ-011 SHALL size the counter at $clog2(max(LONG_TICKS, DOUBLE_TICKS))+1 bits, so the counter never wraps within a state.
REQ-012 SHALL, in S_IDLE with btn_level=1, clear the counter and go to S_PRESS1; otherwise it stays in S_IDLE.
REQ-013 SHALL, in S_PRESS1, increment the counter each edge.
  - btn_level=0: clear the counter and go to S_WAIT2.
  - else, if counter==LONG_TICKS-1: pulse long_press and go to S_LONG_HELD.
REQ-014 SHALL, in S_LONG_HELD, stay in the state while btn_level=1 and emit no further events; btn_level=0 returns it to S_IDLE.
REQ-015 SHALL, in S_WAIT2, increment the counter each edge.
  - btn_level=1: clear the counter and go to S_PRESS2.
  - else, if counter==DOUBLE_TICKS-1: pulse click and go to S_IDLE.
REQ-016 SHALL, in S_PRESS2, increment the counter each edge.
  - btn_level=0: pulse double_click and go to S_IDLE.
  - else, if counter==LONG_TICKS-1: pulse double_click and go to S_LONG_HELD.
REQ-017 SHALL give the btn_level edge priority over a counter terminal match on the same edge (release beats long timeout; second press beats click timeout).
REQ-018 SHALL register the event outputs: each is high for exactly one cycle, in the cycle after the edge that made the qualifying transition.
REQ-019 SHALL keep click, double_click and long_press mutually exclusive, with at most one event per gesture.
REQ-020 SHALL derive busy combinationally from the state (busy = state != S_IDLE).
REQ-021 SHALL treat an illegal or unreachable state encoding as S_IDLE on the next edge, with all events low.
REQ-022 SHALL NOT need btn_level to be low at power-up: a level already high when reset releases starts a gesture in S_PRESS1.

Reset
REQ-023 SHALL, when rst=1 on an edge, force state to S_IDLE, clear the counter and drive click, double_click and long_press to 0 on that edge; busy=0 follows.
REQ-024 SHALL let rst override every transition, including mid-gesture, and SHALL emit no event for an aborted gesture.

Verification (LONG_TICKS=8, DOUBLE_TICKS=4)
REQ-025 Single click: btn_level high for 3 edges, then low -> click high for 1 cycle after the 4th edge following the release edge; no other event.
REQ-026 Double click: high 2, low 2, high 3, low -> double_click high for 1 cycle after the release edge; click never asserts.
REQ-027 Long press: high for 12 edges -> long_press high for 1 cycle after the 8th edge following the press edge; no event at release; busy=0 after release.
REQ-028 Priority: release sampled on the edge where the PRESS1 counter==7 -> no long_press; FSM enters S_WAIT2; click follows 4 edges later.
REQ-029 Reset mid-gesture: rst=1 during S_WAIT2 with counter=2 -> busy=0 and no events; after rst deasserts with btn_level low, no click appears.
REQ-030 Long second press: high 2, low 1, high 10 -> a single double_click 8 edges after the second press edge, no long_press, FSM in S_LONG_HELD until release.
